multimode_ringcounter: RTL and testbench

Parametrised next-generation ring counter for sequencing and one-hot phase generation. Width N, run-time selectable one-hot ring or Johnson (twisted-ring) mode, bidirectional stepping, and parallel load. Also provides a phase index, a wrap pulse and an illegal-state flag. Drop-in successor to the existing fixed one-hot ring counter (clk, en, q).

---
 rtl/multimode_ringcounter.sv | 71 +++++++
 tb/tb_multimode_ringcounter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/multimode_ringcounter.sv
// multimode_ringcounter: N-bit one-hot/Johnson ring counter with direction, load, phase, wrap and illegal flag; define RINGCOUNTER_SELFCORRECT_EN to reseed illegal states on a step
module multimode_ringcounter #(
  parameter int N  = 4,
  parameter int PW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          mode,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  q,
  output logic [PW-1:0] phase,
  output logic          wrap,
  output logic          illegal
);
  localparam logic [N-1:0] seed = N'(1);
  logic          mode_q;
  logic          fix;
  logic          wrap_nx;
  logic [N-1:0]  q_nx;
  logic [PW-1:0] phase_nx;
  logic [PW-1:0] last;
  // ring needs exactly one hot bit; Johnson tolerates at most one boundary between runs
  always_comb illegal = mode ? ($countones(q[N-2:0] ^ q[N-1:1]) > 1) : ($countones(q) != 1);
`ifdef RINGCOUNTER_SELFCORRECT_EN
  assign fix = illegal;
`else
  assign fix = 1'b0;
`endif
  // next state in priority order: mode change, load, self-correct, step, hold
  always_comb begin
    last     = mode_q ? PW'(2*N-1) : PW'(N-1);
    q_nx     = q;
    phase_nx = phase;
    wrap_nx  = 1'b0;
    if (mode != mode_q) begin
      q_nx     = seed;
      phase_nx = '0;
    end else if (load) begin
      q_nx     = load_val;
      phase_nx = '0;
    end else if (en && fix) begin
      q_nx     = seed;
      phase_nx = '0;
    end else if (en && !dir) begin
      q_nx     = {q[N-2:0], q[N-1] ^ mode_q};
      phase_nx = (phase == last) ? '0 : phase + 1'b1;
      wrap_nx  = phase == last;
    end else if (en) begin
      q_nx     = {q[0] ^ mode_q, q[N-1:1]};
      phase_nx = (phase == '0) ? last : phase - 1'b1;
      wrap_nx  = phase == '0;
    end
  end
  // state registers; reset captures the live mode so no reseed follows release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= seed;
      phase  <= '0;
      wrap   <= 1'b0;
      mode_q <= mode;
    end else begin
      q      <= q_nx;
      phase  <= phase_nx;
      wrap   <= wrap_nx;
      mode_q <= mode;
    end
  end
endmodule

// File: tb/tb_multimode_ringcounter.sv
// tb_multimode_ringcounter: scoreboard bench with a behavioural model for multimode_ringcounter
module tb_multimode_ringcounter;
  localparam int N  = 4;
  localparam int PW = $clog2(2*N);
  logic clk = 0, reset = 0, en = 0, mode = 0, dir = 0, load = 0;
  logic [N-1:0]  load_val = '0;
  logic [N-1:0]  q;
  logic [PW-1:0] phase;
  logic          wrap, illegal;
  typedef struct {logic [N-1:0] q; int ph; bit w; bit il;} exp_t;
  exp_t sb[$];
  int passed = 0, total = 0;
  logic [N-1:0] m_q = 1;
  int m_ph = 0;
  bit m_w = 0, m_mode = 0;

  always #5 clk = ~clk;

  multimode_ringcounter #(.N(N)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q), .phase(phase), .wrap(wrap), .illegal(illegal)
  );

  function automatic bit is_illegal(logic [N-1:0] v, bit m);
    int c = 0;
    if (!m) begin
      for (int i = 0; i < N; i++) c += int'(v[i]);
      return c != 1;
    end
    for (int i = 0; i < N-1; i++) c += int'(v[i] != v[i+1]);
    return c > 1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
  endtask

  task automatic seed_model(bit m);
    m_q = 1; m_ph = 0; m_w = 0; m_mode = m;
  endtask

  task automatic cyc(bit r, bit e, bit m, bit d, bit l, logic [N-1:0] lv);
    int p;
    logic [N-1:0] b;
    @(negedge clk);
    reset = r; en = e; mode = m; dir = d; load = l; load_val = lv;
    p = m_mode ? 2*N : N;
    if (!r || m != m_mode) seed_model(m);
    else if (l) begin m_q = lv; m_ph = 0; m_w = 0; end
    else if (e) begin
`ifdef RINGCOUNTER_SELFCORRECT_EN
      if (is_illegal(m_q, m_mode)) seed_model(m_mode);
      else
`endif
      if (!d) begin
        b = N'(m_mode ? !m_q[N-1] : m_q[N-1]);
        m_q = (m_q << 1) | b;
        m_w = (m_ph == p-1);
        m_ph = (m_ph + 1) % p;
      end else begin
        b = N'(m_mode ? !m_q[0] : m_q[0]);
        m_q = (m_q >> 1) | (b << (N-1));
        m_w = (m_ph == 0);
        m_ph = (m_ph + p - 1) % p;
      end
    end else m_w = 0;
    sb.push_back('{m_q, m_ph, m_w, is_illegal(m_q, m)});
  endtask

  // monitor: the counter presents a new output every edge
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("q", 32'(q), 32'(e.q));
      check("phase", 32'(phase), 32'(e.ph));
      check("wrap", 32'(wrap), 32'(e.w));
      check("illegal", 32'(illegal), 32'(e.il));
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (4) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    repeat (8) cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 1, 4'b0101);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 4'b0101);
    cyc(1, 0, 1, 0, 1, 4'b1100);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    #2 reset = 0;
    #1;
    seed_model(mode);
    check("async_q", 32'(q), 32'(1));
    check("async_phase", 32'(phase), 32'(0));
    check("async_wrap", 32'(wrap), 32'(0));
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    repeat (400) begin
      bit r, e, m, d, l;
      r = $urandom_range(0, 39) != 0;
      e = $urandom_range(0, 3) != 0;
      m = ($urandom_range(0, 19) == 0) ? !m_mode : m_mode;
      d = $urandom_range(0, 1) == 1;
      l = $urandom_range(0, 9) == 0;
      cyc(r, e, m, d, l, N'($urandom));
    end
    repeat (2) @(posedge clk);
    #3;
    if (sb.size() != 0) check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
